// File: rtl/mmio_uart_pkg.sv
// Shared constants and state encoding for the memory-mapped UART transmitter.
package mmio_uart_pkg;

   localparam int unsigned UART_CTRL_OFS        = 8;
   localparam int unsigned UART_DATA_OFS        = 12;
   localparam int unsigned READY_BIT            = 0;
   localparam int unsigned OVERRUN_BIT          = 1;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_baud.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
   import mmio_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (reset || clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: CTRL/DATA register decode, one-deep holding register,
// sticky overrun flag and an 8N1 serialiser with a registered line output.
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for the holding register to fill
//   TX_START | start bit (line low) for one bit period
//   TX_DATA  | eight data bits, LSB first
//   TX_STOP  | stop bit (line high); chains straight into TX_START if a byte waits
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        TxSerial,
   output logic        TxBusy
);

   localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'(UART_CTRL_OFS);
   localparam logic [31:0] DATA_ADDR = BASE_ADDR + 32'(UART_DATA_OFS);

   logic        sel_ctrl;
   logic        sel_data;
   logic        ctrl_wr;
   logic        data_wr;
   logic [7:0]  hold;
   logic        hold_valid;
   logic        overrun;
   logic        consume;
   logic [31:0] status;

   tx_state_e   state;
   logic [7:0]  shift;
   logic [2:0]  bit_idx;
   logic        tx_line;
   logic        tick;

   logic        unused_ok;
   assign unused_ok = ^{Address[1:0], WriteData[31:8]};

   assign sel_ctrl = (Address[31:2] == CTRL_ADDR[31:2]);
   assign sel_data = (Address[31:2] == DATA_ADDR[31:2]);
   assign Hit      = sel_ctrl | sel_data;
   assign ctrl_wr  = MemWrite & sel_ctrl;
   assign data_wr  = MemWrite & sel_data;

   always_comb begin
      status              = '0;
      status[READY_BIT]   = ~hold_valid;
      status[OVERRUN_BIT] = overrun;
   end

   always_comb begin
      ReadData = '0;
      if (MemRead) begin
         if (sel_ctrl) begin
            ReadData = status;
         end else if (sel_data) begin
            ReadData = {24'h0, hold};
         end
      end
   end

   // The FSM takes the held byte when idle or at the final cycle of a stop bit.
   assign consume = hold_valid & ((state == TX_IDLE) | ((state == TX_STOP) & tick));

   always_ff @(posedge clk) begin
      if (reset) begin
         hold       <= '0;
         hold_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (data_wr && !hold_valid) begin
            hold       <= WriteData[7:0];
            hold_valid <= 1'b1;
         end else if (consume) begin
            hold_valid <= 1'b0;
         end
         // A write that finds the buffer full is dropped even if it drains this edge.
         if (data_wr && hold_valid) begin
            overrun <= 1'b1;
         end else if (ctrl_wr && WriteData[OVERRUN_BIT]) begin
            overrun <= 1'b0;
         end
      end
   end

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (state == TX_IDLE),
      .tick  (tick)
   );

   // tx_line is loaded with the level of the state being entered, so it tracks state exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= TX_IDLE;
         shift   <= '0;
         bit_idx <= '0;
         tx_line <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               if (hold_valid) begin
                  shift   <= hold;
                  state   <= TX_START;
                  tx_line <= 1'b0;
               end
            end
            TX_START: begin
               if (tick) begin
                  bit_idx <= '0;
                  state   <= TX_DATA;
                  tx_line <= shift[0];
               end
            end
            TX_DATA: begin
               if (tick) begin
                  shift   <= shift >> 1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state   <= TX_STOP;
                     tx_line <= 1'b1;
                  end else begin
                     tx_line <= shift[1];
                  end
               end
            end
            TX_STOP: begin
               if (tick) begin
                  if (hold_valid) begin
                     shift   <= hold;
                     state   <= TX_START;
                     tx_line <= 1'b0;
                  end else begin
                     state   <= TX_IDLE;
                     tx_line <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= TX_IDLE;
               tx_line <= 1'b1;
            end
         endcase
      end
   end

   assign TxSerial = tx_line;
   assign TxBusy   = (state != TX_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed and randomized checks of mmio_uart_tx against a line-level reference model.
module tb_mmio_uart_tx;

   localparam int          CPB  = 4;
   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam logic [31:0] CTRL = BASE + 32'd8;
   localparam logic [31:0] DATA = BASE + 32'd12;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;
   logic        TxSerial;
   logic        TxBusy;

   mmio_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ReadData  (ReadData),
      .Hit       (Hit),
      .TxSerial  (TxSerial),
      .TxBusy    (TxBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Ideal 8N1 waveform, one sample per clock: start, 8 data bits LSB first, stop.
   function automatic logic [39:0] exp_frame(input logic [7:0] b);
      logic [39:0] v;
      for (int i = 0; i < 10 * CPB; i++) begin
         int bp;
         bp = i / CPB;
         if (bp == 0)      v[i] = 1'b0;
         else if (bp == 9) v[i] = 1'b1;
         else              v[i] = b[bp-1];
      end
      return v;
   endfunction

   function automatic logic [7:0] mid_byte(input logic [39:0] f);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = f[CPB*(i+1) + CPB/2];
      return b;
   endfunction

   // Line receiver: records each frame's start cycle, decoded byte, and exact shape.
   logic        mon_active = 1'b0;
   int          mon_cnt    = 0;
   logic [39:0] mon_bits   = '1;
   int          frame_err  = 0;
   logic [7:0]  rx_q[$];
   int          start_q[$];

   always @(negedge clk) begin
      if (reset) begin
         mon_active <= 1'b0;
      end else if (!mon_active) begin
         if (TxSerial === 1'b0) begin
            mon_active <= 1'b1;
            mon_cnt    <= 1;
            mon_bits   <= {TxSerial, mon_bits[39:1]};
            start_q.push_back(cyc);
         end
      end else begin
         mon_bits <= {TxSerial, mon_bits[39:1]};
         if (mon_cnt == 10 * CPB - 1) begin
            rx_q.push_back(mid_byte({TxSerial, mon_bits[39:1]}));
            if ({TxSerial, mon_bits[39:1]} !== exp_frame(mid_byte({TxSerial, mon_bits[39:1]})))
               frame_err <= frame_err + 1;
            mon_active <= 1'b0;
         end else begin
            mon_cnt <= mon_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int wc);
      Address   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1 MemWrite = 1'b0;
      @(negedge clk);
      wc = cyc;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
      Address = a;
      MemRead = 1'b1;
      #1;
      d = ReadData;
      h = Hit;
      MemRead = 1'b0;
   endtask

   task automatic poll_ready();
      logic [31:0] d;
      logic        h;
      for (int i = 0; i < 200; i++) begin
         bus_read(CTRL, d, h);
         if (d[0]) break;
         @(negedge clk);
      end
      chk("ready_poll", {63'd0, d[0]}, 64'd1);
   endtask

   task automatic wait_idle();
      logic [31:0] d;
      logic        h;
      for (int i = 0; i < 3000; i++) begin
         bus_read(CTRL, d, h);
         if (!TxBusy && d[0]) break;
         @(negedge clk);
      end
      chk("idle_wait", {63'd0, TxBusy}, 64'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic        h;
      logic [39:0] obs;
      logic [39:0] busy_v;
      int          wc, wc2, rx_base, st_base, lows;
      logic [7:0]  exp_q[$];
      logic [7:0]  b;
      logic        ovr_exp;

      reset = 1'b1; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state
      chk("rst_txserial", {63'd0, TxSerial}, 64'd1);
      chk("rst_txbusy",   {63'd0, TxBusy},   64'd0);
      bus_read(CTRL, d, h);
      chk("rst_ctrl", {32'd0, d}, 64'h1);
      bus_read(DATA, d, h);
      chk("rst_data", {32'd0, d}, 64'h0);
      @(negedge clk);

      // single byte with exact waveform
      bus_write(DATA, 32'h0000_00A5, wc);
      chk("a5_line_before_start", {63'd0, TxSerial}, 64'd1);
      bus_read(CTRL, d, h);
      chk("a5_ctrl_after_write", {32'd0, d}, 64'h0);
      @(negedge clk);
      for (int i = 0; i < 10 * CPB; i++) begin
         obs[i]    = TxSerial;
         busy_v[i] = TxBusy;
         if (i == 0) begin
            bus_read(CTRL, d, h);
            chk("a5_ready_after_consume", {32'd0, d}, 64'h1);
         end
         @(negedge clk);
      end
      chk("a5_frame", {24'd0, obs}, {24'd0, exp_frame(8'hA5)});
      chk("a5_busy", {24'd0, busy_v}, {24'd0, 40'hFF_FFFF_FFFF});
      chk("a5_start_latency", 64'(start_q[$] - wc), 64'd1);
      chk("a5_end_busy", {63'd0, TxBusy}, 64'd0);
      chk("a5_end_line", {63'd0, TxSerial}, 64'd1);

      // decode
      bus_read(BASE + 32'hE, d, h);
      chk("dec_data_offset_hit", {63'd0, h}, 64'd1);
      chk("dec_data_offset_rd", {32'd0, d}, 64'hA5);
      @(negedge clk);
      bus_read(BASE + 32'h10, d, h);
      chk("dec_miss_hit", {63'd0, h}, 64'd0);
      chk("dec_miss_rd", {32'd0, d}, 64'h0);
      @(negedge clk);
      Address = DATA;
      MemRead = 1'b0;
      #1;
      chk("dec_noread_rd", {32'd0, ReadData}, 64'h0);
      chk("dec_noread_hit", {63'd0, Hit}, 64'd1);
      @(negedge clk);
      bus_read(BASE + 32'h9, d, h);
      chk("dec_ctrl_offset_rd", {32'd0, d}, 64'h1);
      bus_read(32'hFFFE_000C, d, h);
      chk("dec_upper_miss_hit", {63'd0, h}, 64'd0);
      @(negedge clk);

      // back-to-back
      rx_base = rx_q.size();
      st_base = start_q.size();
      bus_write(DATA, 32'h55, wc);
      @(negedge clk);
      poll_ready();
      bus_write(DATA, 32'hFF, wc2);
      wait_idle();
      chk("b2b_count", 64'(rx_q.size() - rx_base), 64'd2);
      if (rx_q.size() - rx_base == 2 && start_q.size() - st_base == 2) begin
         chk("b2b_byte0", {56'd0, rx_q[rx_base]}, 64'h55);
         chk("b2b_byte1", {56'd0, rx_q[rx_base+1]}, 64'hFF);
         chk("b2b_gap", 64'(start_q[st_base+1] - start_q[st_base]), 64'(10 * CPB));
      end
      bus_read(CTRL, d, h);
      chk("b2b_ctrl_end", {32'd0, d}, 64'h1);
      @(negedge clk);

      // overrun
      rx_base = rx_q.size();
      bus_write(DATA, 32'h11, wc);
      @(negedge clk);
      bus_write(DATA, 32'h22, wc);
      bus_write(DATA, 32'h33, wc);
      bus_read(CTRL, d, h);
      chk("ovr_ctrl_running", {32'd0, d}, 64'h2);
      wait_idle();
      bus_read(CTRL, d, h);
      chk("ovr_ctrl_idle", {32'd0, d}, 64'h3);
      @(negedge clk);
      bus_write(CTRL, 32'hFFFF_FFFD, wc);
      bus_read(CTRL, d, h);
      chk("ovr_w0_keeps", {32'd0, d}, 64'h3);
      @(negedge clk);
      bus_write(CTRL, 32'h2, wc);
      bus_read(CTRL, d, h);
      chk("ovr_cleared", {32'd0, d}, 64'h1);
      chk("ovr_count", 64'(rx_q.size() - rx_base), 64'd2);
      if (rx_q.size() - rx_base == 2) begin
         chk("ovr_byte0", {56'd0, rx_q[rx_base]}, 64'h11);
         chk("ovr_byte1", {56'd0, rx_q[rx_base+1]}, 64'h22);
      end
      @(negedge clk);

      // randomized: accepted writes go out in order; a write hitting a full buffer sets overrun
      rx_base = rx_q.size();
      ovr_exp = 1'b0;
      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(0, 45)) @(negedge clk);
         poll_ready();
         b = 8'($urandom_range(0, 255));
         bus_write(DATA, {$urandom_range(0, 16'hFFFF), 8'h00, b}, wc);
         exp_q.push_back(b);
         if ($urandom_range(0, 2) == 0) begin
            bus_write(DATA, 32'($urandom_range(0, 255)), wc);
            ovr_exp = 1'b1;
         end
      end
      wait_idle();
      chk("rnd_count", 64'(rx_q.size() - rx_base), 64'(exp_q.size()));
      for (int n = 0; n < exp_q.size(); n++) begin
         if (rx_base + n < rx_q.size())
            chk($sformatf("rnd_byte%0d", n), {56'd0, rx_q[rx_base+n]}, {56'd0, exp_q[n]});
      end
      bus_read(CTRL, d, h);
      chk("rnd_ctrl", {32'd0, d}, {62'd0, ovr_exp, 1'b1});
      @(negedge clk);
      bus_write(CTRL, 32'h2, wc);

      // reset mid-frame during data bit 3 of 8'h0F
      rx_base = rx_q.size();
      bus_write(DATA, 32'h0F, wc);
      @(negedge clk);
      repeat (CPB * 4 + 1) @(negedge clk);
      st_base = start_q.size();
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_line", {63'd0, TxSerial}, 64'd1);
      chk("mrst_busy", {63'd0, TxBusy}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         if (TxSerial !== 1'b1 || TxBusy !== 1'b0) lows++;
         @(negedge clk);
      end
      chk("mrst_no_resume", 64'(lows), 64'd0);
      chk("mrst_no_rx", 64'(rx_q.size() - rx_base), 64'd0);
      chk("mrst_no_start", 64'(start_q.size() - st_base), 64'd0);
      bus_read(CTRL, d, h);
      chk("mrst_ctrl", {32'd0, d}, 64'h1);
      bus_read(DATA, d, h);
      chk("mrst_data", {32'd0, d}, 64'h0);

      chk("frame_shape_errors", 64'(frame_err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
